// File: rtl/dual_issue_ctrl_pkg.sv
// Shared definitions for the dual-issue sequencer: state encoding, slot
// layout, and the destination/mem-op helpers the forwarding unit also uses.
package dual_issue_ctrl_pkg;

  localparam int AWIDTH = 5;
  localparam logic [AWIDTH-1:0] REG_RA = 5'd31;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PAIR    = 2'd1;
  localparam logic [1:0] ST_S2_PEND = 2'd2;

  // One decoded instruction slot as held in the pair register.
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              reg_dst;
    logic              alu_src;
    logic              jal;
    logic              jr;
    logic              memtoreg;
    logic              memwrite;
    logic [AWIDTH-1:0] rs;
    logic [AWIDTH-1:0] rt;
    logic [AWIDTH-1:0] rd;
  } slot_t;

  // Why a pair was split; any bit set forces serial issue.
  typedef struct packed {
    logic ctrl;
    logic mem;
    logic waw;
    logic raw;
  } hz_reason_t;

  function automatic logic is_mem_op(input slot_t s);
    return s.memtoreg | s.memwrite;
  endfunction

  // jal links to $ra, R-type writes rd, everything else writes rt.
  function automatic logic [AWIDTH-1:0] dest_sel(input slot_t s);
    if (s.jal)          return REG_RA;
    else if (s.reg_dst) return s.rd;
    else                return s.rt;
  endfunction

  // Writes to $0 are discarded, so they never create a dependence.
  function automatic logic dest_valid(input slot_t s);
    return s.reg_write && (dest_sel(s) != '0);
  endfunction

endpackage

// File: rtl/dual_issue_ctrl_pair_hazard_chk.sv
// pair_hazard_chk: combinational intra-pair hazard check. Slot 1 is older.
module pair_hazard_chk
  import dual_issue_ctrl_pkg::*;
(
  input  slot_t      s1,
  input  slot_t      s2,
  output logic       hazard,
  output hz_reason_t reason
);

  logic [AWIDTH-1:0] d1;
  logic              d1_ok;
  logic              rs_rd;
  logic              rt_rd;
  logic              unused_bits;

  assign d1    = dest_sel(s1);
  assign d1_ok = dest_valid(s1);
  assign rs_rd = !s2.jal;
  assign rt_rd = !s2.alu_src || s2.memwrite;

  // Fields that play no part in the pair check.
  assign unused_bits = ^{s1.valid, s1.rs, s1.rt, s2.valid, s2.jr};

  // Each hazard class evaluated independently, then ORed.
  always_comb begin
    reason      = '0;
    reason.raw  = d1_ok && ((rs_rd && (s2.rs == d1)) || (rt_rd && (s2.rt == d1)));
    reason.waw  = d1_ok && dest_valid(s2) && (dest_sel(s2) == d1);
    reason.mem  = is_mem_op(s1) && is_mem_op(s2);
    reason.ctrl = s1.jr || s1.jal;
    hazard      = |reason;
  end

endmodule

// File: rtl/dual_issue_ctrl.sv
// dual_issue_ctrl: holds a decoded pair and issues it in one cycle or two.
// Optional pair statistics counters are built when DUAL_ISSUE_STATS_EN is
// defined; otherwise the counter ports read 0.
module dual_issue_ctrl
  import dual_issue_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_stall,
  input  logic              lane0_busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              s1_i_valid,
  input  logic              s1_i_reg_write,
  input  logic              s1_i_reg_dst,
  input  logic              s1_i_alu_src,
  input  logic              s1_i_jal,
  input  logic              s1_i_jr,
  input  logic              s1_i_memtoreg,
  input  logic              s1_i_memwrite,
  input  logic [AWIDTH-1:0] s1_i_addr_rs,
  input  logic [AWIDTH-1:0] s1_i_addr_rt,
  input  logic [AWIDTH-1:0] s1_i_addr_rd,
  input  logic              s2_i_valid,
  input  logic              s2_i_reg_write,
  input  logic              s2_i_reg_dst,
  input  logic              s2_i_alu_src,
  input  logic              s2_i_jal,
  input  logic              s2_i_jr,
  input  logic              s2_i_memtoreg,
  input  logic              s2_i_memwrite,
  input  logic [AWIDTH-1:0] s2_i_addr_rs,
  input  logic [AWIDTH-1:0] s2_i_addr_rt,
  input  logic [AWIDTH-1:0] s2_i_addr_rd,
  output logic              is_o_lane0_valid,
  output logic              is_o_lane1_valid,
  output logic              is_o_choose_comp,
  output logic [CNT_W-1:0]  is_o_dual_cnt,
  output logic [CNT_W-1:0]  is_o_split_cnt
);

  logic [1:0]  state_q, state_d;
  slot_t       s1_q, s2_q, s1_in, s2_in;
  logic        hazard;
  hz_reason_t  hz_reason_unused;
  logic        active, capture, done, split, dual;
  logic        lane0, lane1, cc, rdy;

  assign s1_in = '{valid: s1_i_valid, reg_write: s1_i_reg_write, reg_dst: s1_i_reg_dst,
                   alu_src: s1_i_alu_src, jal: s1_i_jal, jr: s1_i_jr,
                   memtoreg: s1_i_memtoreg, memwrite: s1_i_memwrite,
                   rs: s1_i_addr_rs, rt: s1_i_addr_rt, rd: s1_i_addr_rd};
  assign s2_in = '{valid: s2_i_valid, reg_write: s2_i_reg_write, reg_dst: s2_i_reg_dst,
                   alu_src: s2_i_alu_src, jal: s2_i_jal, jr: s2_i_jr,
                   memtoreg: s2_i_memtoreg, memwrite: s2_i_memwrite,
                   rs: s2_i_addr_rs, rt: s2_i_addr_rt, rd: s2_i_addr_rd};

  pair_hazard_chk u_hz (
    .s1     (s1_q),
    .s2     (s2_q),
    .hazard (hazard),
    .reason (hz_reason_unused)
  );

  // Issue decision for the held pair plus handshake and next state.
  always_comb begin
    lane0  = 1'b0;
    lane1  = 1'b0;
    cc     = 1'b0;
    done   = 1'b0;
    split  = 1'b0;
    dual   = 1'b0;
    active = !rst && !flush && !ex_stall;
    if (active) begin
      case (state_q)
        ST_EMPTY: begin end
        ST_PAIR: begin
          if (s1_q.valid && s2_q.valid) begin
            if (lane0_busy) begin
              // Lane 0 occupied: slot 1 borrows lane 1, slot 2 follows.
              lane1 = 1'b1;
              cc    = 1'b1;
              split = 1'b1;
            end else if (hazard) begin
              lane0 = 1'b1;
              split = 1'b1;
            end else begin
              lane0 = 1'b1;
              lane1 = 1'b1;
              done  = 1'b1;
              dual  = 1'b1;
            end
          end else begin
            done = 1'b1;
            if (s1_q.valid) begin
              if (lane0_busy) begin
                lane1 = 1'b1;
                cc    = 1'b1;
              end else begin
                lane0 = 1'b1;
              end
            end else if (s2_q.valid) begin
              lane1 = 1'b1;
            end
          end
        end
        ST_S2_PEND: begin
          lane1 = 1'b1;
          done  = 1'b1;
        end
        default: done = 1'b1;
      endcase
    end
    rdy     = active && ((state_q == ST_EMPTY) || done);
    capture = in_valid && rdy;
    state_d = state_q;
    if (capture)    state_d = ST_PAIR;
    else if (done)  state_d = ST_EMPTY;
    else if (split) state_d = ST_S2_PEND;
  end

  assign in_ready         = rdy;
  assign is_o_lane0_valid = lane0;
  assign is_o_lane1_valid = lane1;
  assign is_o_choose_comp = cc;

  // State and pair register; flush drops the pair, stall freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      s1_q    <= '0;
      s2_q    <= '0;
    end else if (flush) begin
      state_q <= ST_EMPTY;
    end else if (!ex_stall) begin
      state_q <= state_d;
      if (capture) begin
        s1_q <= s1_in;
        s2_q <= s2_in;
      end
    end
  end

`ifdef DUAL_ISSUE_STATS_EN
  logic [CNT_W-1:0] dual_cnt_q, split_cnt_q;

  // Saturating pair statistics; dual/split are already gated by stall/flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      dual_cnt_q  <= '0;
      split_cnt_q <= '0;
    end else begin
      if (dual && (dual_cnt_q != {CNT_W{1'b1}}))
        dual_cnt_q <= dual_cnt_q + CNT_W'(1);
      if (split && (split_cnt_q != {CNT_W{1'b1}}))
        split_cnt_q <= split_cnt_q + CNT_W'(1);
    end
  end

  assign is_o_dual_cnt  = dual_cnt_q;
  assign is_o_split_cnt = split_cnt_q;
`else
  assign is_o_dual_cnt  = '0;
  assign is_o_split_cnt = '0;
`endif

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Bench for dual_issue_ctrl: directed pairs with literal checks, plus a
// pair-level reference model compared against the DUT every cycle.
module tb_dual_issue_ctrl;
  import dual_issue_ctrl_pkg::*;

`ifdef DUAL_ISSUE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_JR = 3, K_JAL = 4, K_ADDI = 5, K_NONE = 6;

  logic clk = 0, rst = 1, flush = 0, ex_stall = 0, lane0_busy = 0, in_valid = 0;
  logic in_ready, lane0_v, lane1_v, choose;
  logic [31:0] dual_cnt, split_cnt;
  slot_t t1 = '0, t2 = '0;

  int n_chk = 0, n_pass = 0;
  bit run = 0;

  always #5 clk = ~clk;

  dual_issue_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_stall(ex_stall),
    .lane0_busy(lane0_busy), .in_valid(in_valid), .in_ready(in_ready),
    .s1_i_valid(t1.valid), .s1_i_reg_write(t1.reg_write), .s1_i_reg_dst(t1.reg_dst),
    .s1_i_alu_src(t1.alu_src), .s1_i_jal(t1.jal), .s1_i_jr(t1.jr),
    .s1_i_memtoreg(t1.memtoreg), .s1_i_memwrite(t1.memwrite),
    .s1_i_addr_rs(t1.rs), .s1_i_addr_rt(t1.rt), .s1_i_addr_rd(t1.rd),
    .s2_i_valid(t2.valid), .s2_i_reg_write(t2.reg_write), .s2_i_reg_dst(t2.reg_dst),
    .s2_i_alu_src(t2.alu_src), .s2_i_jal(t2.jal), .s2_i_jr(t2.jr),
    .s2_i_memtoreg(t2.memtoreg), .s2_i_memwrite(t2.memwrite),
    .s2_i_addr_rs(t2.rs), .s2_i_addr_rt(t2.rt), .s2_i_addr_rd(t2.rd),
    .is_o_lane0_valid(lane0_v), .is_o_lane1_valid(lane1_v), .is_o_choose_comp(choose),
    .is_o_dual_cnt(dual_cnt), .is_o_split_cnt(split_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  function automatic slot_t mk(input int kind, input int rs, input int rt, input int rd);
    slot_t s = '0;
    s.valid = (kind != K_NONE);
    s.rs = 5'(rs); s.rt = 5'(rt); s.rd = 5'(rd);
    case (kind)
      K_R:    begin s.reg_write = 1; s.reg_dst = 1; end
      K_LW:   begin s.reg_write = 1; s.alu_src = 1; s.memtoreg = 1; end
      K_SW:   begin s.alu_src = 1; s.memwrite = 1; end
      K_JR:   s.jr = 1;
      K_JAL:  begin s.jal = 1; s.reg_write = 1; end
      K_ADDI: begin s.reg_write = 1; s.alu_src = 1; end
      default: ;
    endcase
    return s;
  endfunction

  // ---------------- reference model (pair level) ----------------
  bit    m_have, m_s1_done;
  slot_t m_s1, m_s2;
  longint m_dual, m_split;

  typedef struct { bit l0, l1, cc, rdy, done, split, dual; } exp_t;

  // Hazard from the instruction-level rules: who writes what, who reads what.
  function automatic bit model_haz(input slot_t a, input slot_t b);
    int da, db, r0, r1;
    bit wa, wb, mema, memb;
    da = a.jal ? 31 : (a.reg_dst ? int'(a.rd) : int'(a.rt));
    db = b.jal ? 31 : (b.reg_dst ? int'(b.rd) : int'(b.rt));
    wa = a.reg_write && da != 0;
    wb = b.reg_write && db != 0;
    r0 = b.jal ? -1 : int'(b.rs);
    r1 = (!b.alu_src || b.memwrite) ? int'(b.rt) : -1;
    mema = a.memtoreg || a.memwrite;
    memb = b.memtoreg || b.memwrite;
    return (wa && (r0 == da || r1 == da)) || (wa && wb && da == db) ||
           (mema && memb) || a.jr || a.jal;
  endfunction

  function automatic exp_t model_eval();
    exp_t e = '{default: 0};
    if (rst || flush || ex_stall) return e;
    if (!m_have) begin
      e.rdy = 1;
    end else if (m_s1_done) begin
      e.l1 = 1; e.done = 1;
    end else if (m_s1.valid && m_s2.valid) begin
      if (lane0_busy)                 begin e.l1 = 1; e.cc = 1; e.split = 1; end
      else if (model_haz(m_s1, m_s2)) begin e.l0 = 1; e.split = 1; end
      else                            begin e.l0 = 1; e.l1 = 1; e.done = 1; e.dual = 1; end
    end else begin
      e.done = 1;
      if (m_s1.valid) begin
        if (lane0_busy) begin e.l1 = 1; e.cc = 1; end else e.l0 = 1;
      end else if (m_s2.valid) e.l1 = 1;
    end
    if (e.done) e.rdy = 1;
    return e;
  endfunction

  // Advance the model on each edge using the inputs present at that edge.
  always @(posedge clk) begin
    exp_t e;
    e = model_eval();
    if (rst) begin
      m_have = 0; m_s1_done = 0; m_s1 = '0; m_s2 = '0; m_dual = 0; m_split = 0;
    end else if (flush) begin
      m_have = 0; m_s1_done = 0;
    end else if (!ex_stall) begin
      if (e.split) begin m_s1_done = 1; if (m_split < 64'hFFFF_FFFF) m_split++; end
      if (e.done)  begin m_have = 0; m_s1_done = 0; end
      if (e.dual && m_dual < 64'hFFFF_FFFF) m_dual++;
      if (e.rdy && in_valid) begin m_have = 1; m_s1_done = 0; m_s1 = t1; m_s2 = t2; end
    end
  end

  // Compare all outputs to the model mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (run) begin
      e = model_eval();
      chk("m_lane0", lane0_v, e.l0);
      chk("m_lane1", lane1_v, e.l1);
      chk("m_choose", choose, e.cc);
      chk("m_in_ready", in_ready, e.rdy);
      chk("m_dual_cnt", dual_cnt, STATS ? m_dual : 0);
      chk("m_split_cnt", split_cnt, STATS ? m_split : 0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic offer(input slot_t a, input slot_t b);
    t1 = a; t2 = b; in_valid = 1;
    @(negedge clk);
    chk("offer_ready", in_ready, 1);
    tick();
    in_valid = 0;
  endtask

  // Offer a pair and wait (bounded) for it to be accepted.
  task automatic run_pair(input slot_t a, input slot_t b, input bit busy);
    bit got = 0;
    int n = 0;
    t1 = a; t2 = b; lane0_busy = busy; in_valid = 1;
    while (!got && n < 8) begin
      @(negedge clk);
      if (in_ready) got = 1;
      tick();
      n++;
    end
    if (!got) chk("accept_timeout", 0, 1);
    in_valid = 0;
  endtask

  initial begin
    tick(); tick();
    run = 1;
    rst = 0;

    // rs RAW: addu $3,$1,$2 ; addu $4,$3,$5
    offer(mk(K_R, 1, 2, 3), mk(K_R, 3, 5, 4));
    @(negedge clk);
    chk("raw_c1_lane0", lane0_v, 1); chk("raw_c1_lane1", lane1_v, 0);
    chk("raw_c1_ready", in_ready, 0);
    tick();
    @(negedge clk);
    chk("raw_c2_lane0", lane0_v, 0); chk("raw_c2_lane1", lane1_v, 1);
    chk("raw_c2_choose", choose, 0);
    tick();
    chk("raw_split_cnt", split_cnt, STATS ? 1 : 0);

    // Write to $0 does not link: dual issue
    offer(mk(K_R, 1, 2, 0), mk(K_R, 0, 0, 4));
    @(negedge clk);
    chk("zero_lane0", lane0_v, 1); chk("zero_lane1", lane1_v, 1);
    chk("zero_choose", choose, 0); chk("zero_ready", in_ready, 1);
    tick();
    chk("zero_dual_cnt", dual_cnt, STATS ? 1 : 0);

    // lane0 busy with independent pair
    lane0_busy = 1;
    offer(mk(K_R, 1, 2, 3), mk(K_R, 4, 5, 6));
    @(negedge clk);
    chk("busy_c1_lane0", lane0_v, 0); chk("busy_c1_lane1", lane1_v, 1);
    chk("busy_c1_choose", choose, 1);
    tick();
    @(negedge clk);
    chk("busy_c2_lane1", lane1_v, 1); chk("busy_c2_choose", choose, 0);
    tick();
    lane0_busy = 0;

    // lw $8,0($9) ; sw $10,4($11)
    offer(mk(K_LW, 9, 8, 0), mk(K_SW, 11, 10, 0));
    @(negedge clk);
    chk("mem_c1_lane0", lane0_v, 1); chk("mem_c1_ready", in_ready, 0);
    tick();
    @(negedge clk);
    chk("mem_c2_lane1", lane1_v, 1); chk("mem_c2_ready", in_ready, 1);
    tick();

    // Stall for 3 cycles in S2_PEND, then slot 2 issues
    offer(mk(K_R, 1, 2, 3), mk(K_R, 3, 5, 4));
    tick();
    ex_stall = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_lane1", lane1_v, 0); chk("stall_ready", in_ready, 0);
      tick();
    end
    ex_stall = 0;
    @(negedge clk);
    chk("stall_rel_lane1", lane1_v, 1); chk("stall_rel_choose", choose, 0);
    tick();

    // Flush in S2_PEND: slot 2 never issues
    offer(mk(K_R, 1, 2, 3), mk(K_R, 3, 5, 4));
    tick();
    flush = 1;
    @(negedge clk);
    chk("flush_lane1", lane1_v, 0); chk("flush_ready", in_ready, 0);
    tick();
    flush = 0;
    @(negedge clk);
    chk("post_flush_lane1", lane1_v, 0); chk("post_flush_ready", in_ready, 1);
    tick();

    // Back-to-back pairs covering remaining hazard classes and slot patterns
    run_pair(mk(K_R, 1, 2, 3),    mk(K_R, 4, 5, 6),    0);  // dual
    run_pair(mk(K_R, 1, 2, 7),    mk(K_R, 4, 5, 7),    0);  // WAW
    run_pair(mk(K_JR, 31, 0, 0),  mk(K_R, 1, 2, 3),    0);  // control
    run_pair(mk(K_JAL, 0, 0, 0),  mk(K_R, 31, 1, 2),   0);  // control + RAW on $ra
    run_pair(mk(K_R, 1, 2, 5),    mk(K_SW, 1, 5, 0),   0);  // RAW via sw rt
    run_pair(mk(K_R, 1, 2, 5),    mk(K_ADDI, 1, 6, 0), 0);  // rt not read: dual
    run_pair(mk(K_R, 1, 2, 3),    mk(K_NONE, 0, 0, 0), 1);  // slot 1 alone on lane 1
    run_pair(mk(K_NONE, 0, 0, 0), mk(K_R, 1, 2, 3),    0);  // slot 2 alone
    run_pair(mk(K_NONE, 0, 0, 0), mk(K_NONE, 0, 0, 0), 0);  // empty pair
    run_pair(mk(K_R, 1, 2, 3),    mk(K_R, 4, 5, 6),    0);
    repeat (3) tick();

    // Reset while a pair is held
    offer(mk(K_R, 1, 2, 3), mk(K_R, 4, 5, 6));
    rst = 1;
    @(negedge clk);
    chk("rst_lane0", lane0_v, 0);
    tick();
    rst = 0;
    @(negedge clk);
    chk("rst_after_lane0", lane0_v, 0); chk("rst_after_lane1", lane1_v, 0);
    chk("rst_after_choose", choose, 0); chk("rst_after_ready", in_ready, 1);
    chk("rst_after_dual", dual_cnt, 0); chk("rst_after_split", split_cnt, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
